// File: rtl/accumulator_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : accumulator_ctrl_pkg
//  Description : Shared types and sizing helpers for the accumulator
//                sequencing controller (state encoding, depth, drain length).
//  Revision    : 1.0  initial release
// ============================================================================
package accumulator_ctrl_pkg;

    // Controller states, explicitly 3 bits wide.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        DRAIN = 3'd2,
        READ  = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Number of accumulator rows available per pass.
    function automatic int get_depth(input int pattern_number, input int systolic_size);
        return pattern_number * systolic_size;
    endfunction

    // Cycles needed for the last column's skew chain to land after column 0.
    function automatic int get_drain_cycles(input int systolic_size);
        return systolic_size - 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/accumulator_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : accumulator_ctrl_if
//  Description : Request, write-stream and read-stream signals between the
//                accumulator controller (slave) and its user (master).
//  Revision    : 1.0  initial release
// ============================================================================
interface accumulator_ctrl_if #(
    parameter int ADDR_WIDTH = 3
);
    logic                  start;
    logic                  start_test;
    logic [ADDR_WIDTH:0]   row_count;
    logic                  in_valid;
    logic                  rd_ready;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic                  test_mode;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_valid;
    logic                  busy;
    logic                  done;
    logic                  err;

    modport master (
        output start, start_test, row_count, in_valid, rd_ready,
        input  wr_en, wr_addr, test_mode, rd_addr, rd_valid, busy, done, err
    );

    modport slave (
        input  start, start_test, row_count, in_valid, rd_ready,
        output wr_en, wr_addr, test_mode, rd_addr, rd_valid, busy, done, err
    );
endinterface
`default_nettype wire

// File: rtl/accumulator_ctrl_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : accumulator_ctrl_cnt
//  Description : Loadable up-counter with enable, synchronous clear and a
//                terminal-count flag against a runtime limit. The count
//                saturates at the limit instead of wrapping.
//  Revision    : 1.0  initial release
// ============================================================================
module accumulator_ctrl_cnt #(
    parameter int WIDTH = 3
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             clear,
    input  wire logic             load,
    input  wire logic [WIDTH-1:0] load_value,
    input  wire logic             en,
    input  wire logic [WIDTH-1:0] limit,
    output logic      [WIDTH-1:0] count,
    output logic                  at_limit
);
    logic [WIDTH-1:0] r_count;

    // Clear beats load beats increment; never step past the limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_value;
        end else if (en && !at_limit) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count    = r_count;
    assign at_limit = (r_count == limit);
endmodule
`default_nettype wire

// File: rtl/accumulator_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : accumulator_ctrl
//  Description : Sequencer for the column-skewed accumulator bank. Emits the
//                write stream while partial sums arrive, waits out the column
//                skew, then streams the rows back over a valid/ready port.
//                Optional macro ACCUM_CTRL_ERR_EN builds a sticky protocol
//                error flag; without it err is tied low.
//  Revision    : 1.0  initial release
// ============================================================================
module accumulator_ctrl
    import accumulator_ctrl_pkg::*;
#(
    parameter int SYSTOLIC_SIZE  = 8,
    parameter int PATTERN_NUMBER = 1,
    parameter int ADDR_WIDTH     = $clog2(PATTERN_NUMBER * SYSTOLIC_SIZE)
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    accumulator_ctrl_if.slave bus
);
    localparam int                  c_depth        = get_depth(PATTERN_NUMBER, SYSTOLIC_SIZE);
    localparam int                  c_drain_cycles = get_drain_cycles(SYSTOLIC_SIZE);
    localparam logic [ADDR_WIDTH:0] c_depth_v      = (ADDR_WIDTH + 1)'(c_depth);

    state_t                r_state;
    logic                  r_mode;
    logic                  r_busy;
    logic                  r_rd_valid;
    logic                  r_done;
    logic [ADDR_WIDTH-1:0] r_last;      // N-1, last row address of this operation

    logic [ADDR_WIDTH:0]   w_clamped;
    logic                  w_start_ok;
    logic                  w_wr_fire;
    logic                  w_wr_tc;
    logic [ADDR_WIDTH-1:0] w_wr_count;
    logic                  w_rd_fire;
    logic                  w_rd_tc;
    logic [ADDR_WIDTH-1:0] w_rd_count;
    logic                  w_drain_tc;

    assign w_clamped  = (bus.row_count > c_depth_v) ? c_depth_v : bus.row_count;
    assign w_start_ok = bus.start && (bus.row_count != '0);
    assign w_wr_fire  = (r_state == WRITE) && bus.in_valid;
    assign w_rd_fire  = r_rd_valid && bus.rd_ready;

    // Write address: restarts at 0 whenever we are not writing.
    accumulator_ctrl_cnt #(.WIDTH(ADDR_WIDTH)) u_wr_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      ((r_state != WRITE) || (w_wr_fire && w_wr_tc)),
        .load       (1'b0),
        .load_value ('0),
        .en         (w_wr_fire),
        .limit      (r_last),
        .count      (w_wr_count),
        .at_limit   (w_wr_tc)
    );

    // Read address: advances only on an accepted handshake.
    accumulator_ctrl_cnt #(.WIDTH(ADDR_WIDTH)) u_rd_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      ((r_state != READ) || (w_rd_fire && w_rd_tc)),
        .load       (1'b0),
        .load_value ('0),
        .en         (w_rd_fire),
        .limit      (r_last),
        .count      (w_rd_count),
        .at_limit   (w_rd_tc)
    );

    // Skew drain timer; a 1x1 array has no skew and needs none.
    generate
        if (c_drain_cycles > 0) begin : g_drain
            localparam int c_drain_w = (c_drain_cycles > 1) ? $clog2(c_drain_cycles) : 1;
            localparam logic [c_drain_w-1:0] c_drain_last = c_drain_w'(c_drain_cycles - 1);
            logic [c_drain_w-1:0] w_drain_count_unused;

            accumulator_ctrl_cnt #(.WIDTH(c_drain_w)) u_drain_cnt (
                .clk        (clk),
                .rst_n      (rst_n),
                .clear      ((r_state != DRAIN) || w_drain_tc),
                .load       (1'b0),
                .load_value ('0),
                .en         (r_state == DRAIN),
                .limit      (c_drain_last),
                .count      (w_drain_count_unused),
                .at_limit   (w_drain_tc)
            );
        end else begin : g_no_drain
            assign w_drain_tc = 1'b1;
        end
    endgenerate

    // Operation sequencer with registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_mode     <= 1'b0;
            r_busy     <= 1'b0;
            r_rd_valid <= 1'b0;
            r_done     <= 1'b0;
            r_last     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_start_ok) begin
                        r_last  <= ADDR_WIDTH'(w_clamped - 1'b1);
                        r_mode  <= bus.start_test;
                        r_busy  <= 1'b1;
                        r_state <= WRITE;
                    end
                end
                WRITE: begin
                    if (w_wr_fire && w_wr_tc) begin
                        // Test passes bypass the skew chain, so no drain.
                        if (r_mode || (c_drain_cycles == 0)) begin
                            r_state    <= READ;
                            r_rd_valid <= 1'b1;
                        end else begin
                            r_state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (w_drain_tc) begin
                        r_state    <= READ;
                        r_rd_valid <= 1'b1;
                    end
                end
                READ: begin
                    if (w_rd_fire && w_rd_tc) begin
                        r_state    <= DONE;
                        r_rd_valid <= 1'b0;
                        r_done     <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_mode  <= 1'b0;
                end
                default: begin
                    r_state    <= IDLE;
                    r_busy     <= 1'b0;
                    r_mode     <= 1'b0;
                    r_rd_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.wr_en     = w_wr_fire;
    assign bus.wr_addr   = w_wr_count;
    assign bus.rd_addr   = w_rd_count;
    assign bus.rd_valid  = r_rd_valid;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.test_mode = r_mode;

`ifdef ACCUM_CTRL_ERR_EN
    logic r_err;
    logic w_err_event;

    assign w_err_event = (bus.start && r_busy)
                       || (bus.in_valid && (r_state != WRITE))
                       || ((r_state == IDLE) && bus.start
                           && ((bus.row_count == '0) || (bus.row_count > c_depth_v)));

    // Sticky protocol error, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_err_event) begin
            r_err <= 1'b1;
        end
    end

    assign bus.err = r_err;
`else
    assign bus.err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_accumulator_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_accumulator_ctrl
//  Description : Self-checking bench for accumulator_ctrl: a table of whole
//                operations with hand-computed timing, plus directed
//                sequences for gapped writes, read back-pressure, clamping,
//                ignored restarts and asynchronous reset mid-read.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_accumulator_ctrl;
    localparam int SS = 8;
    localparam int PN = 1;
    localparam int AW = 3;
`ifdef ACCUM_CTRL_ERR_EN
    localparam int ERR_EN = 1;
`else
    localparam int ERR_EN = 0;
`endif

    typedef struct {
        int row_count;
        int mode;
        int exp_writes;   // also the number of reads
        int exp_gap;      // cycles from last write to first rd_valid
        int exp_total;    // cycles from start cycle to done cycle, inclusive
    } op_vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    op_vec_t vecs[6];
    bit      pat[7]      = '{1, 0, 0, 1, 1, 0, 1};
    bit      rdy[7]      = '{0, 1, 0, 0, 1, 1, 1};
    int      exp_rdad[7] = '{0, 0, 1, 1, 1, 2, 3};

    always #5 clk = ~clk;

    accumulator_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

    accumulator_ctrl #(
        .SYSTOLIC_SIZE  (SS),
        .PATTERN_NUMBER (PN),
        .ADDR_WIDTH     (AW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " wr_en"},     int'(bus.wr_en),     0);
        chk({tag, " wr_addr"},   int'(bus.wr_addr),   0);
        chk({tag, " test_mode"}, int'(bus.test_mode), 0);
        chk({tag, " rd_addr"},   int'(bus.rd_addr),   0);
        chk({tag, " rd_valid"},  int'(bus.rd_valid),  0);
        chk({tag, " busy"},      int'(bus.busy),      0);
        chk({tag, " done"},      int'(bus.done),      0);
        chk({tag, " err"},       int'(bus.err),       0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One complete operation with continuous in_valid and rd_ready=1.
    task automatic run_op(input op_vec_t v, input string tag, input bit restart);
        int writes = 0, reads = 0, dones = 0;
        int last_wr = -1, first_rd = -1, done_k = -1, idle_k = -1;
        int tm_bad = 0, wr_bad = 0, rd_bad = 0;
        @(negedge clk);
        bus.start      = 1'b1;
        bus.start_test = v.mode[0];
        bus.row_count  = (AW + 1)'(v.row_count);
        bus.in_valid   = 1'b1;
        bus.rd_ready   = 1'b1;
        #1;
        chk({tag, " busy before accept"}, int'(bus.busy), 0);
        for (int k = 1; k <= 200 && idle_k < 0; k++) begin
            @(negedge clk);
            bus.start = (restart && k == 1);
            #1;
            if (bus.busy && int'(bus.test_mode) != v.mode) tm_bad++;
            if (!bus.busy && bus.test_mode) tm_bad++;
            if (bus.wr_en) begin
                if (int'(bus.wr_addr) != writes) wr_bad++;
                writes++;
                last_wr = k;
            end
            if (bus.rd_valid) begin
                if (first_rd < 0) first_rd = k;
                if (int'(bus.rd_addr) != reads) rd_bad++;
                reads++;
            end
            if (bus.done) begin
                dones++;
                done_k = k;
            end
            if (!bus.busy) idle_k = k;
        end
        bus.in_valid = 1'b0;
        chk({tag, " finished in budget"}, int'(idle_k > 0), 1);
        chk({tag, " writes"},        writes,             v.exp_writes);
        chk({tag, " reads"},         reads,              v.exp_writes);
        chk({tag, " wr order"},      wr_bad,             0);
        chk({tag, " rd order"},      rd_bad,             0);
        chk({tag, " wr-rd gap"},     first_rd - last_wr, v.exp_gap);
        chk({tag, " done pulses"},   dones,              1);
        chk({tag, " start-to-done"}, done_k + 1,         v.exp_total);
        chk({tag, " busy fall"},     idle_k,             done_k + 1);
        chk({tag, " test_mode"},     tm_bad,             0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int waited;
        int found;

        vecs[0] = '{row_count: 8,  mode: 0, exp_writes: 8, exp_gap: 8, exp_total: 25};
        vecs[1] = '{row_count: 4,  mode: 1, exp_writes: 4, exp_gap: 1, exp_total: 10};
        vecs[2] = '{row_count: 1,  mode: 0, exp_writes: 1, exp_gap: 8, exp_total: 11};
        vecs[3] = '{row_count: 12, mode: 0, exp_writes: 8, exp_gap: 8, exp_total: 25};
        vecs[4] = '{row_count: 3,  mode: 1, exp_writes: 3, exp_gap: 1, exp_total: 8};
        vecs[5] = '{row_count: 5,  mode: 0, exp_writes: 5, exp_gap: 8, exp_total: 19};

        bus.start      = 1'b0;
        bus.start_test = 1'b0;
        bus.row_count  = '0;
        bus.in_valid   = 1'b0;
        bus.rd_ready   = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // start with row_count=0 is ignored
        @(negedge clk);
        bus.start     = 1'b1;
        bus.row_count = '0;
        @(negedge clk);
        bus.start = 1'b0;
        #1;
        chk("rc0 ignored busy", int'(bus.busy), 0);

        // Table of whole operations
        foreach (vecs[i]) begin
            run_op(vecs[i], $sformatf("vec%0d", i), 1'b0);
        end

        // Gapped in_valid and rd_ready back-pressure, row_count=4
        do_reset();
        @(negedge clk);
        bus.start      = 1'b1;
        bus.start_test = 1'b0;
        bus.row_count  = 4'd4;
        bus.in_valid   = 1'b0;
        bus.rd_ready   = 1'b0;
        n = 0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            bus.start    = 1'b0;
            bus.in_valid = pat[i];
            #1;
            chk($sformatf("gap wr_en[%0d]", i), int'(bus.wr_en), int'(pat[i]));
            if (pat[i]) begin
                chk($sformatf("gap wr_addr[%0d]", i), int'(bus.wr_addr), n);
                n++;
            end
        end
        @(negedge clk);
        bus.in_valid = 1'b1;
        #1;
        chk("gap wr_en after 4th", int'(bus.wr_en), 0);
        chk("gap busy in drain", int'(bus.busy), 1);
        waited = 0;
        found  = 0;
        for (int j = 0; j < 20 && found == 0; j++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            bus.rd_ready = 1'b0;
            #1;
            waited++;
            if (bus.rd_valid) found = 1;
        end
        chk("gap rd_valid seen", found, 1);
        chk("gap drain wait", waited, 7);
        for (int i = 0; i < 7; i++) begin
            if (i > 0) begin
                @(negedge clk);
                bus.rd_ready = rdy[i];
                #1;
            end
            chk($sformatf("bp rd_valid[%0d]", i), int'(bus.rd_valid), 1);
            chk($sformatf("bp rd_addr[%0d]", i),  int'(bus.rd_addr),  exp_rdad[i]);
        end
        @(negedge clk);
        bus.rd_ready = 1'b0;
        #1;
        chk("bp done", int'(bus.done), 1);
        chk("bp rd_valid low", int'(bus.rd_valid), 0);
        @(negedge clk);
        #1;
        chk("bp busy low", int'(bus.busy), 0);

        // Clamp to DEPTH plus ignored second start, then sticky err
        do_reset();
        run_op(vecs[3], "clamp", 1'b1);
        chk("clamp err", int'(bus.err), ERR_EN);
        repeat (3) @(negedge clk);
        #1;
        chk("clamp err sticky", int'(bus.err), ERR_EN);
        chk("clamp stays idle", int'(bus.busy), 0);

        // Asynchronous reset in the middle of READ
        do_reset();
        @(negedge clk);
        bus.start      = 1'b1;
        bus.start_test = 1'b0;
        bus.row_count  = 4'd8;
        bus.in_valid   = 1'b1;
        bus.rd_ready   = 1'b1;
        found = 0;
        for (int j = 0; j < 60 && found == 0; j++) begin
            @(negedge clk);
            bus.start = 1'b0;
            #1;
            if (bus.rd_valid && bus.rd_addr == 3'd5) found = 1;
        end
        chk("rstmid reached addr5", found, 1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("rstmid");
        @(negedge clk);
        rst_n        = 1'b1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        bus.start      = 1'b1;
        bus.start_test = 1'b1;
        bus.row_count  = 4'd2;
        @(negedge clk);
        bus.start    = 1'b0;
        bus.in_valid = 1'b1;
        #1;
        chk("post-rst wr_en", int'(bus.wr_en), 1);
        chk("post-rst wr_addr0", int'(bus.wr_addr), 0);
        chk("post-rst test_mode", int'(bus.test_mode), 1);
        @(negedge clk);
        #1;
        chk("post-rst wr_addr1", int'(bus.wr_addr), 1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        chk("post-rst rd_valid", int'(bus.rd_valid), 1);
        chk("post-rst rd_addr", int'(bus.rd_addr), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
